// File: rtl/dmem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_pkg : shared funct3 encodings and FSM state type for dmem     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_lane_align : byte-lane mask, store steering, load extension   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        fault
);

  logic [31:0] w_shifted;

  assign w_shifted = rword >> {addr_lo, 3'b000};

  always_comb begin
    fault      = 1'b0;
    byte_en    = 4'b0000;
    wdata_lane = wdata;
    rdata_ext  = 32'h0;
    case (funct3)
      F3_B, F3_BU: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = funct3[2] ? {24'h0, w_shifted[7:0]}
                               : {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      F3_H, F3_HU: begin
        fault      = addr_lo[0];
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = funct3[2] ? {16'h0, w_shifted[15:0]}
                               : {{16{w_shifted[15]}}, w_shifted[15:0]};
      end
      F3_W: begin
        fault     = (addr_lo != 2'b00);
        byte_en   = 4'b1111;
        rdata_ext = rword;
      end
      default: fault = 1'b1;
    endcase
    // A faulting access neither writes nor returns data
    if (fault) begin
      byte_en   = 4'b0000;
      rdata_ext = 32'h0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_bytelane.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_bytelane : RV32I byte-lane data memory with post-reset clear  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        access_fault,
  output logic        busy
);

  localparam int c_depth = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_idx_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [31:0]           r_mem [c_depth];
  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_clr_idx;
  logic                  r_busy;

  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           w_rword;
  logic [3:0]            w_byte_en;
  logic [31:0]           w_wdata_lane;
  logic [31:0]           w_rdata_ext;
  logic                  w_fault;
  logic                  w_ready;
  logic                  w_clearing;
  logic                  w_commit;
  logic                  w_unused_addr;

  assign w_idx         = addr[ADDR_WIDTH+1:2];
  assign w_unused_addr = ^addr[31:ADDR_WIDTH+2];
  assign w_rword       = r_mem[w_idx];

  dmem_lane_align u_align (
    .addr_lo    (addr[1:0]),
    .funct3     (funct3),
    .wdata      (wdata),
    .rword      (w_rword),
    .byte_en    (w_byte_en),
    .wdata_lane (w_wdata_lane),
    .rdata_ext  (w_rdata_ext),
    .fault      (w_fault)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CLEAR:   if (r_clr_idx == {ADDR_WIDTH{1'b1}}) w_state_next = READY;
      READY:   w_state_next = READY;
      default: w_state_next = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= CLEAR_ON_RESET ? CLEAR : READY;
      r_clr_idx <= '0;
      r_busy    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == CLEAR);
      if (r_state == CLEAR) r_clr_idx <= r_clr_idx + c_idx_one;
    end
  end

  // Busy also covers the reset cycles themselves and the first cycle after
  // release when no clear is performed.
  assign busy       = r_busy | ~reset;
  assign w_ready    = (r_state == READY) && !busy;
  assign w_clearing = reset && (r_state == CLEAR);
  assign w_commit   = w_ready && we && !w_fault;

  always_ff @(posedge clk) begin
    if (w_clearing) begin
      r_mem[r_clr_idx] <= 32'h0;
    end else if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_byte_en[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_lane[8*i +: 8];
      end
    end
  end

  assign rdata        = w_ready ? w_rdata_ext : 32'h0;
  assign access_fault = w_ready ? w_fault : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bytelane.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dmem_bytelane : directed + random checks against a byte model   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_dmem_bytelane;

  logic        clk = 1'b0;
  logic        reset, reset1, we;
  logic [31:0] addr, wdata;
  logic [2:0]  funct3;
  logic [31:0] rdata, rdata1;
  logic        access_fault, fault1, busy, busy1;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [64];

  always #5 clk = ~clk;

  dmem_bytelane dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
    .funct3(funct3), .rdata(rdata), .access_fault(access_fault), .busy(busy)
  );

  dmem_bytelane #(.ADDR_WIDTH(6), .CLEAR_ON_RESET(1'b0)) dut_noclr (
    .clk(clk), .reset(reset1), .addr(addr), .wdata(wdata), .we(we),
    .funct3(funct3), .rdata(rdata1), .access_fault(fault1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes, 0 for an unsupported funct3
  function automatic int m_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit m_fault(input logic [2:0] f3, input logic [31:0] a);
    int sz = m_size(f3);
    return (sz == 0) || ((int'(a % 4) % sz) != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    int     sz, off, idx;
    longint word, v, full;
    if (m_fault(f3, a)) return 32'h0;
    sz   = m_size(f3);
    off  = int'(a % 4);
    idx  = int'((a / 4) % 64);
    word = longint'(model[idx]);
    full = longint'(1) << (8 * sz);
    v    = (word >> (8 * off)) % full;
    if (!f3[2] && sz < 4 && v >= full / 2) v = v - full;
    return v[31:0];
  endfunction

  task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int sz  = m_size(f3);
    int off = int'(a % 4);
    int idx = int'((a / 4) % 64);
    for (int k = 0; k < sz; k++) model[idx][8*(off+k) +: 8] = wd[8*k +: 8];
  endtask

  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic w, output logic [31:0] obs);
    logic [31:0] er;
    logic        ef;
    funct3 = f3; addr = a; wdata = wd; we = w;
    @(negedge clk);
    er = m_load(f3, a);
    ef = m_fault(f3, a);
    chk({tag, "/rdata"}, rdata, er);
    chk({tag, "/fault"}, {31'b0, access_fault}, {31'b0, ef});
    obs = rdata;
    @(posedge clk); #1;
    if (w && !ef) m_store(f3, a, wd);
    we = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] obs;
    logic        b1a, b1b;
    int          n;

    reset = 1'b0; reset1 = 1'b0; we = 1'b0;
    funct3 = 3'b011; addr = 32'h0; wdata = 32'h0;
    b1a = 1'b0; b1b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_fault", {31'b0, access_fault}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1; reset1 = 1'b1;
    foreach (model[i]) model[i] = 32'h0;

    // Count busy cycles of the clearing instance, sampling the no-clear one
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 200) begin
      if (n == 0) b1a = busy1;
      if (n == 1) b1b = busy1;
      n++;
      @(negedge clk);
    end
    chk("clear_len", n, 32'd64);
    chk("noclr_busy_c1", {31'b0, b1a}, 32'd1);
    chk("noclr_busy_c2", {31'b0, b1b}, 32'd0);
    @(posedge clk); #1;

    do_op("lw00", 3'b010, 32'h00, 32'h0, 1'b0, obs); chk("lw00_c", obs, 32'h0);
    do_op("lw7c", 3'b010, 32'h7C, 32'h0, 1'b0, obs); chk("lw7c_c", obs, 32'h0);
    do_op("lwfc", 3'b010, 32'hFC, 32'h0, 1'b0, obs); chk("lwfc_c", obs, 32'h0);

    do_op("sw10", 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, obs);
    do_op("lb10", 3'b000, 32'h10, 32'h0, 1'b0, obs);  chk("lb10_c", obs, 32'hFFFFFFEF);
    do_op("lbu13", 3'b100, 32'h13, 32'h0, 1'b0, obs); chk("lbu13_c", obs, 32'h000000DE);
    do_op("lh12", 3'b001, 32'h12, 32'h0, 1'b0, obs);  chk("lh12_c", obs, 32'hFFFFDEAD);
    do_op("lhu10", 3'b101, 32'h10, 32'h0, 1'b0, obs); chk("lhu10_c", obs, 32'h0000BEEF);

    do_op("sb11", 3'b000, 32'h11, 32'h00000055, 1'b1, obs);
    do_op("lw10a", 3'b010, 32'h10, 32'h0, 1'b0, obs); chk("lane_sb", obs, 32'hDEAD55EF);
    do_op("sh12", 3'b001, 32'h12, 32'h00001234, 1'b1, obs);
    do_op("lw10b", 3'b010, 32'h10, 32'h0, 1'b0, obs); chk("lane_sh", obs, 32'h123455EF);

    do_op("sw21", 3'b010, 32'h21, 32'hFFFFFFFF, 1'b1, obs);
    chk("sw21_fault_c", {31'b0, access_fault}, 32'd1);
    do_op("sh23", 3'b001, 32'h23, 32'hFFFFFFFF, 1'b1, obs);
    chk("sh23_fault_c", {31'b0, access_fault}, 32'd1);
    do_op("lw20", 3'b010, 32'h20, 32'h0, 1'b0, obs); chk("lw20_c", obs, 32'h0);
    do_op("f3_011", 3'b011, 32'h20, 32'h0, 1'b0, obs);
    chk("f3_011_fault_c", {31'b0, access_fault}, 32'd1);
    chk("f3_011_rdata_c", obs, 32'h0);

    do_op("sw104", 3'b010, 32'h104, 32'hA5A5A5A5, 1'b1, obs);
    do_op("lw004", 3'b010, 32'h004, 32'h0, 1'b0, obs); chk("wrap_c", obs, 32'hA5A5A5A5);

    // Store and load of the same word in one cycle sees old data
    do_op("sw10same", 3'b010, 32'h10, 32'h0BADF00D, 1'b1, obs);
    chk("same_cycle_c", obs, 32'h123455EF);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra;
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      do_op("rnd", 3'($urandom_range(0, 7)), ra, $urandom, 1'($urandom_range(0, 1)), obs);
    end

    // Mid-clear reset, with a store held during the whole clear
    reset = 1'b0; @(posedge clk); #1; reset = 1'b1;
    repeat (30) @(posedge clk);
    #1; reset = 1'b0; @(posedge clk); #1; reset = 1'b1;
    funct3 = 3'b010; addr = 32'h0; wdata = 32'hFFFFFFFF; we = 1'b1;
    @(negedge clk);
    chk("busy_rdata", rdata, 32'h0);
    chk("busy_fault", {31'b0, access_fault}, 32'd0);
    count_busy(n);
    we = 1'b0;
    chk("midclr_len", n, 32'd64);
    foreach (model[i]) model[i] = 32'h0;
    @(posedge clk); #1;
    do_op("lw0_post", 3'b010, 32'h00, 32'h0, 1'b0, obs); chk("busy_store_c", obs, 32'h0);
    do_op("lw10_post", 3'b010, 32'h10, 32'h0, 1'b0, obs); chk("recleared_c", obs, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_bytelane.md
# dmem_bytelane

Parametrised byte-lane data memory for the single-cycle RV32I core. It replaces the word-only data memory and executes the RV32I load/store widths selected by funct3: LB/LH/LW/LBU/LHU and SB/SH/SW. It flags misaligned or unsupported accesses. After reset it clears the array sequentially while holding `busy` high, so the core can stall.

## Interface
Parameters:
- `ADDR_WIDTH`, default 6: word-address bits; depth = 2^ADDR_WIDTH 32-bit words.
- `CLEAR_ON_RESET`, default 1: 1 = zero the whole array after reset; 0 = skip the clear, contents undefined.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-low.
- `addr` in 32: byte address from the ALU.
- `wdata` in 32: store data (rs2), right-aligned.
- `we` in 1: store request.
- `funct3` in 3: access width and sign.
- `rdata` out 32: extended load result (combinational).
- `access_fault` out 1: misaligned or unsupported funct3 (combinational).
- `busy` out 1: clear in progress; the core must stall.

## Operation
- Array: 2^ADDR_WIDTH x 32. Word index = `addr[ADDR_WIDTH+1:2]`. Upper address bits are ignored, so addresses wrap modulo depth.
- FSM states:
  - CLEAR. Each cycle, write 0 to `mem[clr_idx]` and increment `clr_idx`. When `clr_idx == DEPTH-1`, that write completes and the FSM moves to READY.
  - READY. Normal operation.
- Reset: `reset==0` at a posedge sets the next state and `clr_idx`:
  - `CLEAR_ON_RESET=1`: state <= CLEAR, `clr_idx <= 0`.
  - `CLEAR_ON_RESET=0`: state <= READY.
- Reset asserted mid-clear restarts the clear from index 0.
- Outputs during reset or CLEAR: `busy=1`, `rdata=0`, `access_fault=0`. Stores are ignored.
- Fault decode, for any funct3 regardless of `we`:
  - Halfword (001/101) with `addr[0]=1`: fault.
  - Word (010) with `addr[1:0]!=0`: fault.
  - funct3 011, 110, 111: fault.
- Store, committed at a posedge only when READY && `we` && !`access_fault`:
  - SB 000: lane `addr[1:0]` <= `wdata[7:0]`.
  - SH 001: lanes {addr[1],0} and {addr[1],1} <= `wdata[15:0]`.
  - SW 010: all lanes <= `wdata`.
  - Other lanes are unchanged.
  - A faulting store writes nothing.
- Load, selected from the word at the index:
  - LB 000: byte `addr[1:0]`, sign-extended.
  - LBU 100: byte `addr[1:0]`, zero-extended.
  - LH 001: halfword `addr[1]`, sign-extended.
  - LHU 101: halfword `addr[1]`, zero-extended.
  - LW 010: full word.
  - Faulting access: `rdata=0`.
- `rdata` is always driven; the core ignores it on stores.

## Timing
- Load: zero latency; `rdata` follows `addr`/`funct3` combinationally.
- Store: visible on `rdata` from the cycle after the committing edge.
- Store and load to the same word in one cycle: `rdata` shows pre-store data until the edge.
- `busy` after reset release:
  - `CLEAR_ON_RESET=1`: `busy` is high for exactly DEPTH cycles (64 at default). It falls in the cycle after the edge that writes index DEPTH-1.
  - `CLEAR_ON_RESET=0`: `busy` falls after the first edge with `reset=1`.
- `clr_idx` is ADDR_WIDTH bits. Terminal detection uses the all-ones compare, not overflow.

## Structure
- Package `dmem_pkg`:
  - funct3 localparams F3_B/H/W/BU/HU.
  - FSM state typedef {CLEAR, READY}.
- Sub-module `dmem_lane_align` (pure combinational):
  - Inputs: `addr[1:0]`, `funct3`, `wdata`, raw word.
  - Outputs: 4-bit byte-write mask, lane-shifted store data, extended load data, fault.
  - Top level keeps the array, FSM and clear counter.

## Test plan
- Reset held 3 cycles, then released: `busy=1` for 64 cycles, then 0. LW at 0x00, 0x7C, 0xFC all return 0x00000000.
- SW 0xDEADBEEF @0x10. Then LB @0x10 = 0xFFFFFFEF, LBU @0x13 = 0x000000DE, LH @0x12 = 0xFFFFDEAD, LHU @0x10 = 0x0000BEEF.
- Lane isolation:
  - After SW 0xDEADBEEF @0x10, SB 0x55 @0x11: LW @0x10 = 0xDEAD55EF.
  - SH 0x1234 @0x12: LW @0x10 = 0x123455EF.
- Faults:
  - SW @0x21 and SH @0x23: `access_fault=1`, and LW @0x20 remains 0.
  - funct3=011 @0x20: `access_fault=1`, `rdata=0`.
- Wrap: SW 0xA5A5A5A5 @0x104 then LW @0x004 returns 0xA5A5A5A5.
- Mid-clear reset:
  - Reset at clear cycle 30 for 1 cycle: `busy` stays high for a further full 64 cycles.
  - SW issued while `busy` has no effect, and its readback is 0.
  - `CLEAR_ON_RESET=0`: `busy` drops 1 cycle after release.
